// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with a 2-flop synchroniser, a local tick divider, 2-of-3 majority
// voting at mid-bit, and parity and stop checks. Each completed frame gives a one-cycle done pulse.
module uart_rx_os #(
  parameter int unsigned CLK_SPEED = 100_000_000,
  parameter int unsigned BAUDRATE  = 921600,
  parameter int unsigned D_BITS    = 8,
  parameter int unsigned SP_BITS   = 1,
  parameter int unsigned OSR       = 16,
  parameter int unsigned PARITY    = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx,
  output logic [D_BITS-1:0] o_data,
  output logic              o_rx_done,
  output logic              o_frame_err,
  output logic              o_parity_err,
  output logic              o_busy
);

  localparam int unsigned DivRaw = (CLK_SPEED + BAUDRATE * OSR / 2) / (BAUDRATE * OSR);
  localparam int unsigned Div    = (DivRaw < 1) ? 1 : DivRaw;
  localparam int unsigned DW     = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned SW     = $clog2(OSR);
  localparam int unsigned BW     = $clog2(D_BITS + 1);
  localparam int unsigned Half   = OSR / 2;

  localparam logic [DW-1:0] DivLast = DW'(Div - 1);
  localparam logic [SW-1:0] SEarly  = SW'(Half - 1);
  localparam logic [SW-1:0] SMid    = SW'(Half);
  localparam logic [SW-1:0] SVote   = SW'(Half + 1);
  localparam logic [SW-1:0] SLast   = SW'(OSR - 1);
  localparam logic [BW-1:0] BitsEnd = BW'(D_BITS);
  localparam logic [1:0]    StopEnd = 2'(SP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q, state_d;
  logic              rx_meta, rx_sync;
  logic [DW-1:0]     div_cnt;
  logic [SW-1:0]     s_cnt;
  logic [SW-1:0]     high_cnt;
  logic [1:0]        samp_q;
  logic [BW-1:0]     bit_cnt;
  logic [1:0]        stop_cnt;
  logic [D_BITS-1:0] shift_q;
  logic              par_q;
  logic              ferr_acc;
  logic              armed;

  logic tick, vote, vote_tick, bit_end, start_det;
  logic done_d, frame_err_d, parity_err_d;

  assign tick      = (div_cnt == DivLast);
  assign vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync) | (samp_q[1] & rx_sync);
  assign vote_tick = tick && (s_cnt == SVote);
  assign bit_end   = tick && (s_cnt == SLast);
  assign start_det = (state_q == StIdle) && armed && !rx_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_det) state_d = StStart;
      StStart: begin
        if (vote_tick && vote) state_d = StIdle;
        else if (bit_end)      state_d = StData;
      end
      StData: begin
        if (bit_end && bit_cnt == BitsEnd) state_d = (PARITY != 0) ? StParity : StStop;
      end
      StParity: if (bit_end) state_d = StStop;
      StStop:   if (vote_tick && stop_cnt == StopEnd) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    o_busy       = (state_q != StIdle);
    done_d       = (state_q == StStop) && vote_tick && (stop_cnt == StopEnd);
    frame_err_d  = ferr_acc | ~vote;
    parity_err_d = 1'b0;
    if (PARITY == 1)      parity_err_d = ~(^shift_q ^ par_q);
    else if (PARITY == 2) parity_err_d = ^shift_q ^ par_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta      <= 1'b1;
      rx_sync      <= 1'b1;
      armed        <= 1'b1;
      div_cnt      <= '0;
      s_cnt        <= '0;
      high_cnt     <= '0;
      samp_q       <= '0;
      bit_cnt      <= '0;
      stop_cnt     <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      ferr_acc     <= 1'b0;
      o_data       <= '0;
      o_rx_done    <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      rx_meta   <= i_rx;
      rx_sync   <= rx_meta;
      o_rx_done <= done_d;

      if (start_det) begin
        // Re-phase the tick so the mid-bit vote lands relative to the detected edge.
        div_cnt  <= '0;
        s_cnt    <= '0;
        bit_cnt  <= '0;
        stop_cnt <= '0;
        ferr_acc <= 1'b0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick && state_q != StIdle) s_cnt <= (s_cnt == SLast) ? '0 : s_cnt + 1'b1;
        if (tick && s_cnt == SEarly) samp_q[0] <= rx_sync;
        if (tick && s_cnt == SMid)   samp_q[1] <= rx_sync;
        if (vote_tick) begin
          case (state_q)
            StData: begin
              shift_q <= {vote, shift_q[D_BITS-1:1]};
              bit_cnt <= bit_cnt + 1'b1;
            end
            StParity: par_q <= vote;
            StStop: begin
              ferr_acc <= ferr_acc | ~vote;
              stop_cnt <= stop_cnt + 1'b1;
            end
            default: ;
          endcase
        end
      end

      if (done_d) begin
        o_data       <= shift_q;
        o_frame_err  <= frame_err_d;
        o_parity_err <= parity_err_d;
      end

      // After a framing error, hold off until the line has idled high for a full bit.
      if (done_d && frame_err_d) begin
        armed    <= 1'b0;
        high_cnt <= '0;
      end else if (!armed && state_q == StIdle && tick) begin
        if (!rx_sync)               high_cnt <= '0;
        else if (high_cnt == SLast) armed    <= 1'b1;
        else                        high_cnt <= high_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboarded bench for uart_rx_os: one instance without parity and one with even parity,
// each fed by its own serial line; monitors pop expected frames on every done pulse.
module tb_uart_rx_os;

  localparam int unsigned Bit = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx0 = 1'b1;
  logic       rx2 = 1'b1;
  logic [7:0] data0, data2;
  logic       done0, ferr0, perr0, busy0;
  logic       done2, ferr2, perr2, busy2;

  exp_t q0[$];
  exp_t q2[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   done_cnt0 = 0;
  int   lat, busy_len, cnt_before;
  logic saw_busy;

  always #5 clk = ~clk;

  uart_rx_os #(
    .CLK_SPEED(16_000_000), .BAUDRATE(1_000_000), .D_BITS(8), .SP_BITS(1), .OSR(16), .PARITY(0)
  ) dut0 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx0), .o_data(data0), .o_rx_done(done0),
    .o_frame_err(ferr0), .o_parity_err(perr0), .o_busy(busy0)
  );

  uart_rx_os #(
    .CLK_SPEED(16_000_000), .BAUDRATE(1_000_000), .D_BITS(8), .SP_BITS(1), .OSR(16), .PARITY(2)
  ) dut2 (
    .i_clk(clk), .i_rst(rst), .i_rx(rx2), .o_data(data2), .o_rx_done(done2),
    .o_frame_err(ferr2), .o_parity_err(perr2), .o_busy(busy2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      done_cnt0++;
      n_cmp++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL dut0 unexpected done: data=%h ferr=%b perr=%b", data0, ferr0, perr0);
      end else begin
        e = q0.pop_front();
        if ({data0, ferr0, perr0} !== e) begin
          n_fail++;
          $display("FAIL dut0 frame: got data=%h ferr=%b perr=%b expected data=%h ferr=%b perr=%b",
                   data0, ferr0, perr0, e.data, e.ferr, e.perr);
        end
      end
    end
    if (done2) begin
      n_cmp++;
      if (q2.size() == 0) begin
        n_fail++;
        $display("FAIL dut2 unexpected done: data=%h ferr=%b perr=%b", data2, ferr2, perr2);
      end else begin
        e = q2.pop_front();
        if ({data2, ferr2, perr2} !== e) begin
          n_fail++;
          $display("FAIL dut2 frame: got data=%h ferr=%b perr=%b expected data=%h ferr=%b perr=%b",
                   data2, ferr2, perr2, e.data, e.ferr, e.perr);
        end
      end
    end
  end

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx0 = v;
    else            rx2 = v;
  endtask

  task automatic drive(input int which, input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      set_line(which, f[i]);
      repeat (Bit) @(negedge clk);
    end
  endtask

  task automatic idle(input int which, input int bits);
    set_line(which, 1'b1);
    repeat (Bit * bits) @(negedge clk);
  endtask

  // No-parity frame: start, 8 data LSB first, one stop.
  task automatic send0(input logic [7:0] d, input logic stop);
    exp_t e;
    e.data = d;
    e.ferr = ~stop;
    e.perr = 1'b0;
    q0.push_back(e);
    drive(0, {6'b0, stop, d, 1'b0}, 10);
  endtask

  // Even parity: error whenever the data plus parity bit hold an odd number of ones.
  task automatic send2(input logic [7:0] d, input logic pbit, input logic stop);
    exp_t e;
    e.data = d;
    e.ferr = ~stop;
    e.perr = ($countones({d, pbit}) % 2) == 1;
    q2.push_back(e);
    drive(2, {5'b0, stop, pbit, d, 1'b0}, 11);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("reset data0", data0, 8'h00);
    chk("reset flags0", {done0, ferr0, perr0, busy0}, 4'b0000);
    chk("reset flags2", {done2, ferr2, perr2, busy2}, 4'b0000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(0, 1);

    // Single frame with latency and busy-length measurement.
    lat = 0;
    busy_len = 0;
    fork
      send0(8'hA5, 1'b1);
      begin
        while (!done0 && lat < 400) begin
          @(negedge clk);
          lat++;
          if (!done0 && busy0) busy_len++;
        end
      end
    join
    chk("latency in [156,158]", (lat >= 156 && lat <= 158), 1);
    chk("busy length ~150", (busy_len >= 140 && busy_len <= 160), 1);
    idle(0, 1);

    // Back-to-back, no idle between frames.
    send0(8'h00, 1'b1);
    send0(8'hFF, 1'b1);
    send0(8'h3C, 1'b1);
    idle(0, 1);

    // Short low glitch must be rejected.
    saw_busy = 1'b0;
    set_line(0, 1'b0);
    repeat (4) begin @(negedge clk); saw_busy |= busy0; end
    set_line(0, 1'b1);
    repeat (12) begin @(negedge clk); saw_busy |= busy0; end
    chk("glitch busy seen", saw_busy, 1'b1);
    chk("glitch busy dropped", busy0, 1'b0);
    chk("glitch data held", data0, 8'h3C);
    idle(0, 1);

    // Even parity correct and wrong.
    send2(8'h07, 1'b1, 1'b1);
    send2(8'h07, 1'b0, 1'b1);
    idle(2, 1);
    chk("parity err held", perr2, 1'b1);

    // Framing error followed by a long break: one pulse only, then recovery.
    cnt_before = done_cnt0;
    send0(8'h3A, 1'b0);
    repeat (40 * Bit) @(negedge clk);
    chk("break single done", done_cnt0 - cnt_before, 1);
    chk("break ferr flag", ferr0, 1'b1);
    idle(0, 2);
    send0(8'h55, 1'b1);
    idle(0, 1);
    chk("recovered ferr", ferr0, 1'b0);

    // Randomised traffic on both lines in parallel.
    fork
      for (int i = 0; i < 20; i++) begin
        send0(8'($urandom), 1'b1);
        idle(0, $urandom_range(0, 2));
      end
      for (int j = 0; j < 20; j++) begin
        send2(8'($urandom), 1'($urandom), 1'b1);
        idle(2, $urandom_range(0, 2));
      end
    join
    idle(0, 1);
    chk("q2 drained", q2.size(), 0);

    // Reset in the middle of data bit 4; frame is lost.
    fork
      drive(0, {6'b0, 1'b1, 8'hC3, 1'b0}, 10);
      begin
        repeat (Bit * 5 + 8) @(negedge clk);
        chk("busy before reset", busy0, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async reset data0", data0, 8'h00);
        chk("async reset flags0", {done0, ferr0, perr0, busy0}, 4'b0000);
      end
    join
    @(negedge clk);
    rst = 1'b0;
    idle(0, 2);
    send0(8'h81, 1'b1);
    idle(0, 2);
    chk("q0 drained", q0.size(), 0);
    chk("final data0", data0, 8'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
